// File: rtl/dkong3_audio_pkg.sv
// Shared types and width helpers for the DK3 APU mixer.
package dkong3_audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    SAT
  } mix_state_t;

  function automatic int GAIN_UNITY(input int gain_w);
    return 1 << (gain_w - 1);
  endfunction

  // Wide enough that NUM_CH full-scale signed*unsigned products cannot overflow.
  function automatic int ACC_W(input int sample_w, input int gain_w, input int num_ch);
    return sample_w + gain_w + $clog2(num_ch) + 1;
  endfunction

endpackage

// File: rtl/dkong3_mix_sat.sv
// Scales the accumulated mix to the output width and clamps it; purely combinational.
// Sits between the accumulator and the output register, so it has no latency or flow control.
module dkong3_mix_sat #(
  parameter int ACC_W = 26,
  parameter int OUT_W = 16,
  parameter int SHR   = 7,
  parameter int SHL   = 0
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [OUT_W-1:0] y,
  output logic                    clip
);

  localparam int LSH = (SHL > 0) ? SHL : 0;
  localparam int RSH = (SHL < 0) ? -SHL : 0;
  localparam int W   = ACC_W + LSH;

  localparam logic signed [W-1:0] MAXV = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {{(W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [W-1:0] v;

  always_comb begin
    v    = W'(acc);
    v    = v >>> SHR;
    v    = v <<< LSH;
    v    = v >>> RSH;
    clip = (v > MAXV) || (v < MINV);
    if (v > MAXV)
      y = MAXV[OUT_W-1:0];
    else if (v < MINV)
      y = MINV[OUT_W-1:0];
    else
      y = v[OUT_W-1:0];
  end

endmodule

// File: rtl/dkong3_apu_mixer.sv
// Snapshots NUM_CH APU samples on a strobe, serially multiply-accumulates one channel per clock,
// and saturates to one signed sample NUM_CH+1 clocks later; strobes while busy are dropped and flagged.
module dkong3_apu_mixer
  import dkong3_audio_pkg::*;
#(
  parameter int                NUM_CH   = 2,
  parameter int                SAMPLE_W = 16,
  parameter int                GAIN_W   = 8,
  parameter int                OUT_W    = 16,
  parameter logic [NUM_CH-1:0] INV_MASK = {NUM_CH{1'b1}}
) (
  input  logic                         I_CLK_12M,
  input  logic                         I_RESET,
  input  logic                         I_SAMPLE_STB,
  input  logic [NUM_CH*SAMPLE_W-1:0]   I_SAMPLES,
  input  logic [NUM_CH-1:0]            I_MUTE,
  input  logic                         I_GAIN_WR,
  input  logic [$clog2(NUM_CH):0]      I_GAIN_SEL,
  input  logic [GAIN_W-1:0]            I_GAIN_D,
  output logic [OUT_W-1:0]             O_SAMPLE,
  output logic                         O_VALID,
  output logic                         O_BUSY,
  output logic                         O_CLIP,
  output logic                         O_OVERRUN
);

  localparam int AW    = ACC_W(SAMPLE_W, GAIN_W, NUM_CH);
  localparam int SEL_W = $clog2(NUM_CH) + 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW    = SAMPLE_W + GAIN_W + 1;

  mix_state_t               state;
  logic [IDX_W-1:0]         ch;
  logic signed [AW-1:0]     acc;
  logic [SAMPLE_W-1:0]      samp_q [NUM_CH];
  logic [NUM_CH-1:0]        mute_q;
  logic [GAIN_W-1:0]        gain_q [NUM_CH];

  logic [SAMPLE_W-1:0]      s_inv;
  logic signed [SAMPLE_W-1:0] s_sgn;
  logic signed [GAIN_W:0]   g_sgn;
  logic signed [PW-1:0]     prod;
  logic signed [AW-1:0]     term;
  logic [OUT_W-1:0]         sat_y;
  logic                     sat_clip;

  // Offset-binary to two's complement is an MSB flip after the optional inversion.
  always_comb begin
    s_inv = INV_MASK[ch] ? ~samp_q[ch] : samp_q[ch];
    s_sgn = {~s_inv[SAMPLE_W-1], s_inv[SAMPLE_W-2:0]};
    g_sgn = {1'b0, gain_q[ch]};
    prod  = s_sgn * g_sgn;
    term  = mute_q[ch] ? '0 : AW'(prod);
  end

  dkong3_mix_sat #(
    .ACC_W (AW),
    .OUT_W (OUT_W),
    .SHR   (GAIN_W - 1),
    .SHL   (OUT_W - SAMPLE_W)
  ) u_sat (
    .acc  (acc),
    .y    (sat_y),
    .clip (sat_clip)
  );

  always_ff @(posedge I_CLK_12M or posedge I_RESET) begin
    if (I_RESET) begin
      for (int i = 0; i < NUM_CH; i++) gain_q[i] <= GAIN_W'(GAIN_UNITY(GAIN_W));
    end else if (I_GAIN_WR && (I_GAIN_SEL < SEL_W'(NUM_CH))) begin
      gain_q[I_GAIN_SEL[IDX_W-1:0]] <= I_GAIN_D;
    end
  end

  always_ff @(posedge I_CLK_12M or posedge I_RESET) begin
    if (I_RESET) begin
      state     <= IDLE;
      ch        <= '0;
      acc       <= '0;
      mute_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) samp_q[i] <= '0;
      O_SAMPLE  <= '0;
      O_VALID   <= 1'b0;
      O_BUSY    <= 1'b0;
      O_CLIP    <= 1'b0;
      O_OVERRUN <= 1'b0;
    end else begin
      O_VALID <= 1'b0;
      if (I_SAMPLE_STB && state != IDLE) O_OVERRUN <= 1'b1;
      case (state)
        IDLE: begin
          // A strobe coinciding with the previous result's valid pulse is dropped.
          if (I_SAMPLE_STB && !O_VALID) begin
            for (int i = 0; i < NUM_CH; i++) samp_q[i] <= I_SAMPLES[i*SAMPLE_W +: SAMPLE_W];
            mute_q <= I_MUTE;
            acc    <= '0;
            ch     <= '0;
            O_BUSY <= 1'b1;
            state  <= ACC;
          end
        end
        ACC: begin
          acc <= acc + term;
          if (ch == IDX_W'(NUM_CH - 1)) state <= SAT;
          else                          ch    <= ch + 1'b1;
        end
        SAT: begin
          O_SAMPLE <= sat_y;
          O_CLIP   <= sat_clip;
          O_VALID  <= 1'b1;
          O_BUSY   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dkong3_apu_mixer.sv
// Randomized bench for dkong3_apu_mixer at default parameters, checked against an arithmetic mix model.
module tb_dkong3_apu_mixer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic [31:0] samples = '0;
  logic [1:0]  mute = '0;
  logic        gain_wr = 1'b0;
  logic [1:0]  gain_sel = '0;
  logic [7:0]  gain_d = '0;
  logic [15:0] o_sample;
  logic        o_valid, o_busy, o_clip, o_overrun;

  int checks = 0;
  int errors = 0;
  int gain [2];

  always #5 clk = ~clk;

  dkong3_apu_mixer dut (
    .I_CLK_12M    (clk),
    .I_RESET      (rst),
    .I_SAMPLE_STB (stb),
    .I_SAMPLES    (samples),
    .I_MUTE       (mute),
    .I_GAIN_WR    (gain_wr),
    .I_GAIN_SEL   (gain_sel),
    .I_GAIN_D     (gain_d),
    .O_SAMPLE     (o_sample),
    .O_VALID      (o_valid),
    .O_BUSY       (o_busy),
    .O_CLIP       (o_clip),
    .O_OVERRUN    (o_overrun)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Both channels inverted at default INV_MASK; full-scale unsigned maps to signed by subtracting mid-scale.
  function automatic void model(input logic [15:0] s0, input logic [15:0] s1, input logic [1:0] m,
                                output longint y, output bit c);
    longint sum, v;
    logic [15:0] s [2];
    s[0] = s0;
    s[1] = s1;
    sum  = 0;
    for (int i = 0; i < 2; i++) begin
      if (!m[i]) begin
        v   = 65535 - longint'(s[i]) - 32768;
        sum = sum + v * longint'(gain[i]);
      end
    end
    v = sum >>> 7;
    c = (v > 32767) || (v < -32768);
    y = (v > 32767) ? 32767 : (v < -32768) ? -32768 : v;
  endfunction

  task automatic wr_gain(input logic [1:0] sel, input logic [7:0] d);
    @(negedge clk);
    gain_wr = 1'b1; gain_sel = sel; gain_d = d;
    @(negedge clk);
    gain_wr = 1'b0;
    if (sel < 2) gain[sel] = int'(d);
  endtask

  task automatic do_mix(input string tag, input logic [15:0] s0, input logic [15:0] s1, input logic [1:0] m,
                        input bit wr, input logic [1:0] wsel, input logic [7:0] wd);
    longint exp_s;
    bit     exp_c;
    int     lat;
    model(s0, s1, m, exp_s, exp_c);
    @(negedge clk);
    samples = {s1, s0}; mute = m; stb = 1'b1;
    @(negedge clk);
    stb = 1'b0; samples = 32'($urandom); mute = 2'($urandom);
    chk({tag, "_busy"}, longint'(o_busy), 1);
    if (wr) begin gain_wr = 1'b1; gain_sel = wsel; gain_d = wd; end
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(negedge clk);
      gain_wr = 1'b0;
      lat++;
    end
    if (wr && wsel < 2) gain[wsel] = int'(wd);
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_sample"}, longint'($signed(o_sample)), exp_s);
    chk({tag, "_clip"}, longint'(o_clip), longint'(exp_c));
    chk({tag, "_busy_done"}, longint'(o_busy), 0);
    @(negedge clk);
    chk({tag, "_valid_pulse"}, longint'(o_valid), 0);
  endtask

  initial begin
    longint exp_s, got_s;
    bit     exp_c;
    int     nv;
    gain[0] = 128; gain[1] = 128;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sample", longint'(o_sample), 0);
    chk("rst_valid", longint'(o_valid), 0);
    chk("rst_busy", longint'(o_busy), 0);
    chk("rst_clip", longint'(o_clip), 0);
    chk("rst_overrun", longint'(o_overrun), 0);

    do_mix("full", 16'hFFFF, 16'hFFFF, 2'b00, 0, 0, 0);
    chk("full_raw", longint'(o_sample), 16'h8000);
    do_mix("mid", 16'h8000, 16'h8000, 2'b00, 0, 0, 0);
    chk("mid_raw", longint'(o_sample), 16'hFFFE);
    do_mix("mute1", 16'h8000, 16'h8000, 2'b10, 0, 0, 0);
    chk("mute1_raw", longint'(o_sample), 16'hFFFF);
    wr_gain(0, 8'h40);
    wr_gain(1, 8'h00);
    do_mix("half", 16'h0000, 16'h1234, 2'b00, 0, 0, 0);
    chk("half_raw", longint'(o_sample), 16'h3FFF);
    chk("no_overrun", longint'(o_overrun), 0);

    // Second strobe one clock late must not restart the mix with the new samples.
    model(16'h1000, 16'h2000, 2'b00, exp_s, exp_c);
    @(negedge clk);
    samples = {16'h2000, 16'h1000}; mute = 2'b00; stb = 1'b1;
    @(negedge clk);
    samples = {16'hF0F0, 16'h0F0F};
    @(negedge clk);
    stb = 1'b0;
    nv = 0; got_s = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_valid) begin nv++; got_s = longint'($signed(o_sample)); end
      @(negedge clk);
    end
    chk("ovr_valid_count", nv, 1);
    chk("ovr_sample", got_s, exp_s);
    chk("ovr_flag", longint'(o_overrun), 1);
    do_mix("after_ovr", 16'h4321, 16'hC000, 2'b00, 0, 0, 0);
    chk("ovr_sticky", longint'(o_overrun), 1);

    do_mix("wr_during", 16'h0100, 16'hA000, 2'b00, 1, 0, 8'hFF);
    do_mix("wr_after", 16'h0100, 16'hA000, 2'b00, 0, 0, 0);
    wr_gain(2, 8'h11);
    do_mix("sel_oob", 16'h7777, 16'h9999, 2'b00, 0, 0, 0);

    @(negedge clk);
    samples = {16'h1111, 16'h2222}; mute = 2'b00; stb = 1'b1;
    @(negedge clk);
    stb = 1'b0; rst = 1'b1;
    #1;
    chk("midrst_busy", longint'(o_busy), 0);
    chk("midrst_valid", longint'(o_valid), 0);
    chk("midrst_overrun", longint'(o_overrun), 0);
    chk("midrst_sample", longint'(o_sample), 0);
    @(negedge clk);
    rst = 1'b0;
    gain[0] = 128; gain[1] = 128;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_valid) nv++;
    end
    chk("midrst_no_valid", nv, 0);
    do_mix("post_rst", 16'h3000, 16'hE000, 2'b00, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 4)
        wr_gain(2'($urandom_range(0, 3)), 8'($urandom));
      do_mix("rand", 16'($urandom), 16'($urandom), 2'($urandom), 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
